icache: RTL and testbench

- Direct-mapped, one-word-per-line instruction cache.
- Sits between the fetch stage and the memory controller's instruction-fetch port.
- Acts as the requesting client of that port: drives IF_valid/IF_addr and consumes the IF_send/IF_inst return.
- Returns hits combinationally. Fills misses through the memory controller.

---
 rtl/icache_pkg.sv | 6 +
 rtl/icache_array.sv | 44 ++++
 rtl/icache.sv | 114 +++++++++++
 tb/tb_icache.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared icache configuration: FSM state encodings and default geometry.
package icache_pkg;
   localparam int         ICACHE_INDEX_BITS = 6;
   localparam logic [0:0] ICACHE_IDLE       = 1'b0;
   localparam logic [0:0] ICACHE_MISS       = 1'b1;
endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: async read, sync write, valid bits cleared by rst.
module icache_array
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = ICACHE_INDEX_BITS,
   parameter int TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_idx_i,
   output logic                  rd_valid_o,
   output logic [TAG_BITS-1:0]   rd_tag_o,
   output logic [31:0]           rd_data_o,
   input  logic                  wr_en_i,
   input  logic [INDEX_BITS-1:0] wr_idx_i,
   input  logic [TAG_BITS-1:0]   wr_tag_i,
   input  logic [31:0]           wr_data_i
);
   localparam int LINES = 2 ** INDEX_BITS;

   logic [LINES-1:0]    valid_q;
   logic [TAG_BITS-1:0] tag_q  [LINES];
   logic [31:0]         data_q [LINES];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   // Tag/data need no reset: they are only observed behind a valid bit.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];
endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-line icache: 0-cycle hits, misses filled via IF_* port with bypass.
// Define ICACHE_STATS_EN to add hit_cnt/miss_cnt counters.
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = ICACHE_INDEX_BITS,
   parameter int TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        jump_rst,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_pc,
   output logic        fetch_hit,
   output logic [31:0] fetch_inst,
   output logic        IF_valid,
   output logic [31:0] IF_addr,
   input  logic        IF_send,
   input  logic [31:0] IF_inst
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);
   logic [0:0]            state_q, state_d;
   logic [29:0]           miss_q, miss_d;
   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   tag;
   logic                  rd_valid;
   logic [TAG_BITS-1:0]   rd_tag;
   logic [31:0]           rd_data;
   logic                  lookup_hit, bypass, start_miss, fill;
   logic                  unused_pc_lsb;

   assign idx           = fetch_pc[INDEX_BITS+1:2];
   assign tag           = fetch_pc[31:INDEX_BITS+2];
   assign unused_pc_lsb = ^fetch_pc[1:0];

   icache_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_array (
      .clk        (clk),
      .rst        (rst),
      .rd_idx_i   (idx),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .wr_en_i    (fill),
      .wr_idx_i   (miss_q[INDEX_BITS-1:0]),
      .wr_tag_i   (miss_q[29:INDEX_BITS]),
      .wr_data_i  (IF_inst)
   );

   assign lookup_hit = fetch_valid && rdy && rd_valid && (rd_tag == tag);
   assign start_miss = (state_q == ICACHE_IDLE) && fetch_valid && rdy && !jump_rst && !lookup_hit;
   // A flush in the same cycle as IF_send discards the fill entirely.
   assign fill       = (state_q == ICACHE_MISS) && IF_send && rdy && !jump_rst;
   assign bypass     = fill && fetch_valid && (fetch_pc[31:2] == miss_q);

   always_comb begin
      state_d = state_q;
      miss_d  = miss_q;
      if (start_miss) begin
         state_d = ICACHE_MISS;
         miss_d  = fetch_pc[31:2];
      end else if ((state_q == ICACHE_MISS) && rdy && (jump_rst || IF_send)) begin
         state_d = ICACHE_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ICACHE_IDLE;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         miss_q  <= miss_d;
      end
   end

   always_comb begin
      fetch_hit  = 1'b0;
      fetch_inst = '0;
      if (!rst) begin
         if (bypass) begin
            fetch_hit  = 1'b1;
            fetch_inst = IF_inst;
         end else if ((state_q == ICACHE_IDLE) && lookup_hit && !jump_rst) begin
            fetch_hit  = 1'b1;
            fetch_inst = rd_data;
         end
      end
   end

   assign IF_valid = (state_q == ICACHE_MISS);
   assign IF_addr  = {miss_q, 2'b00};

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (rdy) begin
         if (fetch_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (start_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized traffic vs a line-array model.
module tb_icache;
   logic        clk = 1'b0;
   logic        rst, rdy, jump_rst, fetch_valid, IF_send;
   logic [31:0] fetch_pc, IF_inst;
   logic        fetch_hit, IF_valid;
   logic [31:0] fetch_inst, IF_addr;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   always #5 clk = ~clk;

   icache dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .jump_rst    (jump_rst),
      .fetch_valid (fetch_valid),
      .fetch_pc    (fetch_pc),
      .fetch_hit   (fetch_hit),
      .fetch_inst  (fetch_inst),
      .IF_valid    (IF_valid),
      .IF_addr     (IF_addr),
      .IF_send     (IF_send),
      .IF_inst     (IF_inst)
`ifdef ICACHE_STATS_EN
      ,
      .hit_cnt     (hit_cnt),
      .miss_cnt    (miss_cnt)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: each line remembers which word address it holds.
   bit        m_pend;
   bit [29:0] m_addr;
   bit        m_vld  [64];
   bit [29:0] m_word [64];
   bit [31:0] m_dat  [64];

   logic        last_hit, last_ifv;
   logic [31:0] last_inst, last_ifaddr;

   task automatic step(input bit fv, input bit [31:0] pc, input bit r, input bit jr,
                       input bit snd, input bit [31:0] inst);
      int        i;
      bit        lk, eh;
      bit [31:0] ei;
      @(negedge clk);
      fetch_valid = fv; fetch_pc = pc; rdy = r; jump_rst = jr; IF_send = snd; IF_inst = inst;
      #2;
      i  = int'(pc[7:2]);
      lk = fv && r && m_vld[i] && (m_word[i] == pc[31:2]);
      if (!m_pend) begin
         eh = lk && !jr;
         ei = m_dat[i];
      end else begin
         eh = snd && fv && r && !jr && (pc[31:2] == m_addr);
         ei = inst;
      end
      last_hit = fetch_hit; last_inst = fetch_inst; last_ifv = IF_valid; last_ifaddr = IF_addr;
      check("fetch_hit", 32'(fetch_hit), 32'(eh));
      if (eh) check("fetch_inst", fetch_inst, ei);
      check("IF_valid", 32'(IF_valid), 32'(m_pend));
      check("IF_addr", IF_addr, {m_addr, 2'b00});
      @(posedge clk);
      if (r) begin
         if (!m_pend) begin
            if (fv && !lk && !jr) begin
               m_pend = 1'b1;
               m_addr = pc[31:2];
            end
         end else if (jr) begin
            m_pend = 1'b0;
         end else if (snd) begin
            m_vld[m_addr[5:0]]  = 1'b1;
            m_word[m_addr[5:0]] = m_addr;
            m_dat[m_addr[5:0]]  = inst;
            m_pend = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; rdy = 1'b1;
      jump_rst = 1'b0; IF_send = 1'b0; IF_inst = '0;
      @(negedge clk);
      check("rst_IF_valid", 32'(IF_valid), 32'd0);
      check("rst_IF_addr", IF_addr, 32'd0);
      check("rst_fetch_hit", 32'(fetch_hit), 32'd0);
      check("rst_fetch_inst", fetch_inst, 32'd0);
      rst = 1'b0;
      m_pend = 1'b0; m_addr = '0;
      for (int k = 0; k < 64; k++) m_vld[k] = 1'b0;
   endtask

   task automatic fill(input bit [31:0] addr, input bit [31:0] data, input int lat);
      step(1, addr, 1, 0, 0, 0);
      check("miss_no_hit", 32'(last_hit), 32'd0);
      for (int k = 0; k < lat - 1; k++) begin
         step(1, addr, 1, 0, 0, 0);
         check("miss_IF_addr", last_ifaddr, addr);
      end
      step(1, addr, 1, 0, 1, data);
      check("bypass_hit", 32'(last_hit), 32'd1);
      check("bypass_inst", last_inst, data);
   endtask

   initial begin
      do_reset();

      // Cold miss then zero-latency hit
      fill(32'h100, 32'h13, 5);
      step(1, 32'h100, 1, 0, 0, 0);
      check("cold_rehit", 32'(last_hit), 32'd1);
      check("cold_rehit_inst", last_inst, 32'h13);

      // Conflict on the same index evicts the resident line
      fill(32'h200, 32'h22, 2);
      step(1, 32'h200, 1, 0, 0, 0);
      check("conflict_new_hit", 32'(last_hit), 32'd1);
      fill(32'h100, 32'h13, 1);

      // Flush together with IF_send: no write, no bypass
      step(1, 32'h40, 1, 0, 0, 0);
      step(1, 32'h40, 1, 0, 0, 0);
      step(1, 32'h40, 1, 1, 1, 32'hDEADBEEF);
      check("flush_send_hit", 32'(last_hit), 32'd0);
      step(0, 0, 1, 0, 0, 0);
      check("flush_ifv_drop", 32'(last_ifv), 32'd0);
      step(1, 32'h40, 1, 0, 0, 0);
      check("flush_no_write", 32'(last_hit), 32'd0);
      step(0, 0, 1, 0, 0, 0);
      check("flush_remiss", 32'(last_ifv), 32'd1);
      step(0, 0, 1, 0, 1, 32'h40404040);
      step(1, 32'h40, 1, 0, 0, 0);
      check("flush_refill_inst", last_inst, 32'h40404040);

      // Flush in IDLE masks the hit but keeps the contents
      fill(32'h80, 32'h80808080, 3);
      step(1, 32'h80, 1, 1, 0, 0);
      check("idle_flush_mask", 32'(last_hit), 32'd0);
      step(1, 32'h80, 1, 0, 0, 0);
      check("retain_hit", 32'(last_hit), 32'd1);
      check("retain_inst", last_inst, 32'h80808080);

      // rdy stall during MISS with an IF_send pulse that must be ignored
      step(1, 32'h144, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step(1, 32'h144, 0, 0, (k == 1), 32'hBAD0BAD0);
         check("stall_hit", 32'(last_hit), 32'd0);
         check("stall_ifv", 32'(last_ifv), 32'd1);
         check("stall_ifaddr", last_ifaddr, 32'h144);
      end
      step(1, 32'h144, 1, 0, 0, 0);
      check("stall_still_miss", 32'(last_ifv), 32'd1);
      step(0, 0, 1, 1, 0, 0);
      step(1, 32'h144, 1, 0, 0, 0);
      check("stall_no_write", 32'(last_hit), 32'd0);
      step(1, 32'h144, 1, 0, 1, 32'h1440);

      // Randomized traffic over a few indexes and aliasing tags
      for (int n = 0; n < 3000; n++) begin
         bit [31:0] pc;
         pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         step($urandom_range(0, 4) != 0, pc, $urandom_range(0, 9) != 0,
              $urandom_range(0, 19) == 0, m_pend && ($urandom_range(0, 3) == 0), $urandom);
      end

`ifdef ICACHE_STATS_EN
      do_reset();
      fill(32'h1000, 32'h1, 2);
      fill(32'h2004, 32'h2, 2);
      fill(32'h3008, 32'h3, 2);
      step(1, 32'h1000, 1, 0, 0, 0);
      step(1, 32'h2004, 1, 0, 0, 0);
      step(1, 32'h3008, 1, 0, 0, 0);
      step(1, 32'h1000, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      check("stats_miss_cnt", miss_cnt, 32'd3);
      check("stats_hit_cnt", hit_cnt, 32'd7);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
